// File: rtl/lane_judge.sv
// Finger-Dancer hit judge: watches per-lane key rises against the armed note
// pattern, issues HIT/PERFECT/MISS pulses and keeps saturating score and combo.
module lane_judge #(
    parameter int WINDOW      = 16,
    parameter int PERFECT_WIN = 4
) (
    input  logic        C,
    input  logic        INIT,
    input  logic [3:0]  I,
    input  logic        NOTE_LD,
    input  logic [3:0]  NOTE,
    output logic        HIT,
    output logic        PERFECT,
    output logic        MISS,
    output logic        BUSY,
    output logic [11:0] SCORE,
    output logic [7:0]  COMBO,
    output logic        STATE_DBG
);

    typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_e;

    state_e      state_q;
    logic [3:0]  prev_q, exp_q, got_q;
    logic [7:0]  t_q;
    logic        hit_q, perfect_q, miss_q, busy_q;
    logic [11:0] score_q;
    logic [7:0]  combo_q;

    logic [3:0]  rise, got_d;
    logic        wrong, judge_hit, judge_perfect, judge_miss, load;
    logic [12:0] score_sum;
    logic [11:0] score_d;
    logic [7:0]  combo_d;

    always_comb begin
        rise          = I & ~prev_q;
        got_d         = got_q | (rise & exp_q);
        wrong         = |(rise & ~exp_q);
        load          = NOTE_LD && (NOTE != 4'b0000);
        judge_hit     = (state_q == ARMED) && !wrong && (got_d == exp_q);
        // A reload while armed forces a verdict on the old note this cycle.
        judge_miss    = (state_q == ARMED) && !judge_hit &&
                        (wrong || NOTE_LD || (t_q == 8'(WINDOW - 1)));
        judge_perfect = judge_hit && (t_q < 8'(PERFECT_WIN));
        score_sum     = {1'b0, score_q} + (judge_perfect ? 13'd2 : 13'd1);
        score_d       = score_q;
        combo_d       = combo_q;
        if (judge_hit) begin
            score_d = score_sum[12] ? 12'hFFF : score_sum[11:0];
            combo_d = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
        end else if (judge_miss) begin
            combo_d = 8'd0;
        end
    end

    always_ff @(posedge C) begin
        if (INIT) begin
            state_q   <= IDLE;
            prev_q    <= 4'b0000;
            exp_q     <= 4'b0000;
            got_q     <= 4'b0000;
            t_q       <= 8'd0;
            hit_q     <= 1'b0;
            perfect_q <= 1'b0;
            miss_q    <= 1'b0;
            busy_q    <= 1'b0;
            score_q   <= 12'd0;
            combo_q   <= 8'd0;
        end else begin
            prev_q    <= I;
            hit_q     <= judge_hit;
            perfect_q <= judge_perfect;
            miss_q    <= judge_miss;
            score_q   <= score_d;
            combo_q   <= combo_d;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        exp_q   <= NOTE;
                        got_q   <= 4'b0000;
                        t_q     <= 8'd0;
                        state_q <= ARMED;
                        busy_q  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (judge_hit || judge_miss) begin
                        if (load) begin
                            exp_q <= NOTE;
                            got_q <= 4'b0000;
                            t_q   <= 8'd0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        got_q <= got_d;
                        t_q   <= t_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign HIT       = hit_q;
    assign PERFECT   = perfect_q;
    assign MISS      = miss_q;
    assign BUSY      = busy_q;
    assign SCORE     = score_q;
    assign COMBO     = combo_q;
    assign STATE_DBG = (state_q == ARMED);

endmodule

// File: tb/tb_lane_judge.sv
// Bench for lane_judge: scenario tasks push expected verdicts to a queue and a
// monitor pops/compares them whenever the DUT pulses HIT/PERFECT/MISS.
module tb_lane_judge;

    logic        C = 1'b0;
    logic        INIT = 1'b1;
    logic [3:0]  I = 4'b0000;
    logic        NOTE_LD = 1'b0;
    logic [3:0]  NOTE = 4'b0000;
    logic        HIT, PERFECT, MISS, BUSY, STATE_DBG;
    logic [11:0] SCORE;
    logic [7:0]  COMBO;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_score = 0;
    int exp_combo = 0;
    logic [22:0] exp_q[$];
    logic [22:0] mon_e;

    always #5 C = ~C;

    lane_judge #(.WINDOW(16), .PERFECT_WIN(4)) dut (
        .C(C), .INIT(INIT), .I(I), .NOTE_LD(NOTE_LD), .NOTE(NOTE),
        .HIT(HIT), .PERFECT(PERFECT), .MISS(MISS), .BUSY(BUSY),
        .SCORE(SCORE), .COMBO(COMBO), .STATE_DBG(STATE_DBG)
    );

    // Verdict monitor: pops one expectation per observed pulse.
    always @(posedge C) begin
        #2;
        if (HIT === 1'b1 || PERFECT === 1'b1 || MISS === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_pulse: got hit=%0b perfect=%0b miss=%0b, required none",
                         HIT, PERFECT, MISS);
            end else begin
                mon_e = exp_q.pop_front();
                if ({HIT, PERFECT, MISS, SCORE, COMBO} !== mon_e) begin
                    tests_failed++;
                    $display("FAIL verdict: got h/p/m=%0b%0b%0b score=%0d combo=%0d, required h/p/m=%0b%0b%0b score=%0d combo=%0d",
                             HIT, PERFECT, MISS, SCORE, COMBO,
                             mon_e[22], mon_e[21], mon_e[20], mon_e[19:8], mon_e[7:0]);
                end
            end
        end
    end

    task automatic cyc(input logic [3:0] i, input logic ld, input logic [3:0] n);
        I = i;
        NOTE_LD = ld;
        NOTE = n;
        @(posedge C);
        @(negedge C);
        NOTE_LD = 1'b0;
    endtask

    task automatic push_verdict(input logic h, input logic p, input logic m);
        if (h) begin
            exp_score = exp_score + (p ? 2 : 1);
            if (exp_score > 4095) exp_score = 4095;
            if (exp_combo < 255) exp_combo = exp_combo + 1;
        end else begin
            exp_combo = 0;
        end
        exp_q.push_back({h, p, m, 12'(exp_score), 8'(exp_combo)});
    endtask

    task automatic test_reset;
        INIT = 1'b1; I = 4'hF; NOTE_LD = 1'b1; NOTE = 4'hF;
        repeat (3) @(posedge C);
        @(negedge C);
        tests_run++;
        if ({HIT, PERFECT, MISS, BUSY, STATE_DBG, SCORE, COMBO} !== 25'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {HIT, PERFECT, MISS, BUSY, STATE_DBG, SCORE, COMBO});
        end
        INIT = 1'b0;
        exp_score = 0;
        exp_combo = 0;
        repeat (3) cyc(4'hF, 1'b0, 4'h0);
        tests_run++;
        if ({BUSY, STATE_DBG} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got busy/state=%b, required 00", {BUSY, STATE_DBG});
        end
        cyc(4'h0, 1'b0, 4'h0);
    endtask

    task automatic test_perfect_chord;
        cyc(4'h0, 1'b1, 4'b0101);
        tests_run++;
        if ({BUSY, STATE_DBG} !== 2'b11) begin
            tests_failed++;
            $display("FAIL chord_busy_rise: got %b, required 11", {BUSY, STATE_DBG});
        end
        cyc(4'b0000, 1'b0, 4'h0);
        cyc(4'b0001, 1'b0, 4'h0);
        push_verdict(1'b1, 1'b1, 1'b0);
        cyc(4'b0101, 1'b0, 4'h0);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL chord_timing: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        tests_run++;
        if (BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL chord_busy_fall: got %b, required 0", BUSY);
        end
        cyc(4'h0, 1'b0, 4'h0);
    endtask

    task automatic test_good_timeout;
        cyc(4'h0, 1'b1, 4'b1000);
        repeat (10) cyc(4'h0, 1'b0, 4'h0);
        push_verdict(1'b1, 1'b0, 1'b0);
        cyc(4'b1000, 1'b0, 4'h0);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL good_timing: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        cyc(4'h0, 1'b0, 4'h0);
        cyc(4'h0, 1'b1, 4'b0010);
        repeat (15) cyc(4'h0, 1'b0, 4'h0);
        tests_run++;
        if (BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_busy_held: got %b, required 1", BUSY);
        end
        push_verdict(1'b0, 1'b0, 1'b1);
        cyc(4'h0, 1'b0, 4'h0);
        tests_run++;
        if (exp_q.size() != 0 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_timing: got pending=%0d busy=%b, required 0 0", exp_q.size(), BUSY);
            exp_q.delete();
        end
    endtask

    task automatic test_wrong_lane;
        cyc(4'h0, 1'b1, 4'b0011);
        push_verdict(1'b0, 1'b0, 1'b1);
        cyc(4'b0100, 1'b0, 4'h0);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL wrong_lane_timing: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        cyc(4'b0101, 1'b0, 4'h0);
        cyc(4'b0101, 1'b0, 4'h0);
        tests_run++;
        if ({HIT, MISS, BUSY} !== 3'b000) begin
            tests_failed++;
            $display("FAIL wrong_lane_after: got hit/miss/busy=%b, required 000", {HIT, MISS, BUSY});
        end
        cyc(4'h0, 1'b0, 4'h0);
    endtask

    task automatic test_reload;
        cyc(4'h0, 1'b1, 4'b0001);
        repeat (3) cyc(4'h0, 1'b0, 4'h0);
        push_verdict(1'b0, 1'b0, 1'b1);
        cyc(4'h0, 1'b1, 4'b0100);
        tests_run++;
        if (exp_q.size() != 0 || BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL reload_miss: got pending=%0d busy=%b, required 0 1", exp_q.size(), BUSY);
            exp_q.delete();
        end
        cyc(4'h0, 1'b0, 4'h0);
        cyc(4'h0, 1'b0, 4'h0);
        push_verdict(1'b1, 1'b1, 1'b0);
        cyc(4'b0100, 1'b0, 4'h0);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL reload_hit: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        cyc(4'h0, 1'b0, 4'h0);
    endtask

    task automatic test_window_edge;
        cyc(4'h0, 1'b1, 4'b0100);
        repeat (15) cyc(4'h0, 1'b0, 4'h0);
        push_verdict(1'b1, 1'b0, 1'b0);
        cyc(4'b0100, 1'b0, 4'h0);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL window_edge_hit: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        cyc(4'h0, 1'b0, 4'h0);
    endtask

    task automatic test_reload_zero;
        cyc(4'h0, 1'b1, 4'b0001);
        cyc(4'h0, 1'b0, 4'h0);
        push_verdict(1'b0, 1'b0, 1'b1);
        cyc(4'h0, 1'b1, 4'h0);
        tests_run++;
        if (exp_q.size() != 0 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reload_zero: got pending=%0d busy=%b, required 0 0", exp_q.size(), BUSY);
            exp_q.delete();
        end
    endtask

    task automatic test_init_abort;
        cyc(4'h0, 1'b1, 4'b0010);
        repeat (2) cyc(4'h0, 1'b0, 4'h0);
        INIT = 1'b1;
        cyc(4'h0, 1'b0, 4'h0);
        INIT = 1'b0;
        exp_score = 0;
        exp_combo = 0;
        tests_run++;
        if ({BUSY, STATE_DBG, SCORE, COMBO} !== 22'd0) begin
            tests_failed++;
            $display("FAIL init_abort: got %h, required 0", {BUSY, STATE_DBG, SCORE, COMBO});
        end
        cyc(4'b0010, 1'b0, 4'h0);
        cyc(4'h0, 1'b0, 4'h0);
    endtask

    task automatic test_saturation;
        for (int n = 0; n < 2100; n++) begin
            cyc(4'h0, 1'b1, 4'b0001);
            push_verdict(1'b1, 1'b1, 1'b0);
            cyc(4'b0001, 1'b0, 4'h0);
            if (n == 299) begin
                tests_run++;
                if (COMBO !== 8'd255) begin
                    tests_failed++;
                    $display("FAIL combo_sat: got %0d, required 255", COMBO);
                end
            end
        end
        tests_run++;
        if (SCORE !== 12'd4095) begin
            tests_failed++;
            $display("FAIL score_sat: got %0d, required 4095", SCORE);
        end
        cyc(4'h0, 1'b1, 4'b0001);
        push_verdict(1'b0, 1'b0, 1'b1);
        cyc(4'b0010, 1'b0, 4'h0);
        tests_run++;
        if (COMBO !== 8'd0 || SCORE !== 12'd4095) begin
            tests_failed++;
            $display("FAIL sat_miss: got combo=%0d score=%0d, required 0 4095", COMBO, SCORE);
        end
        cyc(4'h0, 1'b0, 4'h0);
    endtask

    initial begin
        test_reset();
        test_perfect_chord();
        test_good_timeout();
        test_wrong_lane();
        test_reload();
        test_window_edge();
        test_reload_zero();
        test_init_abort();
        test_saturation();
        repeat (3) cyc(4'h0, 1'b0, 4'h0);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drained: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
